// File: rtl/eva_ahb_slv.sv
// AHB-Lite word-addressed memory slave with optional wait states and a
// two-cycle ERROR response for illegal transfers.
module eva_ahb_slv #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WAIT_CYC  = 0
) (
    input  logic        hclk,
    input  logic        hrest,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [31:0] haddr,
    input  logic [1:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready_in,
    output logic        hready_out,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata,
    output logic [15:0] err_cnt
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [32:0] SPAN  = 33'(4 * DEPTH);
    localparam logic [2:0]  WLAST = 3'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR1,
        ERR2
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic          pend_q, pend_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [31:0]   mem_q [DEPTH];

    logic          accept;
    logic          legal;
    logic          complete;
    logic [32:0]   offset;
    logic [AW-1:0] index;

    // An address below BASE_ADDR borrows into bit 32, so one compare covers both bounds.
    always_comb begin
        offset   = {1'b0, haddr} - {1'b0, BASE_ADDR};
        index    = offset[AW+1:2];
        legal    = (hsize == 2'b10) && (haddr[1:0] == 2'b00) && (offset < SPAN);
        accept   = hsel && (htrans == 2'b10 || htrans == 2'b11) && hready_in &&
                   (state_q == IDLE || state_q == ERR2);
        complete = (state_q == IDLE) && pend_q;
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        pend_d     = pend_q;
        write_d    = write_q;
        addr_d     = addr_q;
        err_cnt_d  = err_cnt_q;
        hready_out = 1'b1;
        hresp      = 2'b00;
        hrdata     = '0;
        case (state_q)
            IDLE, ERR2: begin
                if (state_q == ERR2) begin
                    hresp = 2'b01;
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end
                if (complete && !write_q) begin
                    hrdata = mem_q[addr_q];
                end
                pend_d  = 1'b0;
                state_d = IDLE;
                // A new address phase overlaps the data phase completing this cycle.
                if (accept) begin
                    write_d = hwrite;
                    addr_d  = index;
                    if (!legal) begin
                        state_d = ERR1;
                    end else begin
                        pend_d = 1'b1;
                        if (WAIT_CYC > 0) begin
                            state_d = WAIT;
                            wcnt_d  = '0;
                        end
                    end
                end
            end
            WAIT: begin
                hready_out = 1'b0;
                if (wcnt_q == WLAST) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            ERR1: begin
                hready_out = 1'b0;
                hresp      = 2'b01;
                state_d    = ERR2;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hrest) begin
        if (hrest) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            pend_q    <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            pend_q    <= pend_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge hclk or posedge hrest) begin
        if (hrest) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (complete && write_q) begin
            mem_q[addr_q] <= hwdata;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_eva_ahb_slv.sv
// Testbench for eva_ahb_slv: three instances (0, 3 and 5 wait states)
// checked against a bench-side memory model and an expectation queue.
module tb_eva_ahb_slv;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 64;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        hrest     [3];
    logic        hsel      [3];
    logic [1:0]  htrans    [3];
    logic        hwrite    [3];
    logic [31:0] haddr     [3];
    logic [1:0]  hsize     [3];
    logic [31:0] hwdata    [3];
    logic        hready_in [3];
    logic        hready_out[3];
    logic [1:0]  hresp     [3];
    logic [31:0] hrdata    [3];
    logic [15:0] err_cnt   [3];

    eva_ahb_slv #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYC(0)) dut0 (
        .hclk(hclk), .hrest(hrest[0]), .hsel(hsel[0]), .htrans(htrans[0]),
        .hwrite(hwrite[0]), .haddr(haddr[0]), .hsize(hsize[0]), .hwdata(hwdata[0]),
        .hready_in(hready_in[0]), .hready_out(hready_out[0]), .hresp(hresp[0]),
        .hrdata(hrdata[0]), .err_cnt(err_cnt[0]));

    eva_ahb_slv #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYC(3)) dut1 (
        .hclk(hclk), .hrest(hrest[1]), .hsel(hsel[1]), .htrans(htrans[1]),
        .hwrite(hwrite[1]), .haddr(haddr[1]), .hsize(hsize[1]), .hwdata(hwdata[1]),
        .hready_in(hready_in[1]), .hready_out(hready_out[1]), .hresp(hresp[1]),
        .hrdata(hrdata[1]), .err_cnt(err_cnt[1]));

    eva_ahb_slv #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYC(5)) dut2 (
        .hclk(hclk), .hrest(hrest[2]), .hsel(hsel[2]), .htrans(htrans[2]),
        .hwrite(hwrite[2]), .haddr(haddr[2]), .hsize(hsize[2]), .hwdata(hwdata[2]),
        .hready_in(hready_in[2]), .hready_out(hready_out[2]), .hresp(hresp[2]),
        .hrdata(hrdata[2]), .err_cnt(err_cnt[2]));

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model[3][DEPTH];
    int          expErr[3];
    int          nCompared   = 0;
    int          nMismatched = 0;

    function automatic int waitsOf(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    task automatic idleBus(input int d);
        hsel[d]      = 1'b0;
        htrans[d]    = 2'b00;
        hwrite[d]    = 1'b0;
        haddr[d]     = 32'h0;
        hsize[d]     = 2'b10;
        hready_in[d] = 1'b1;
    endtask

    // One non-pipelined transfer; called #1 after a rising edge, returns likewise.
    task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size, input logic [31:0] wdata,
                                 input string tag);
        exp_t e, got;
        logic legal, done;
        int   idx, waitsSeen, cycles;
        legal   = (size == 2'b10) && (addr[1:0] == 2'b00) && (addr >= BASE) &&
                  (addr < BASE + 32'(4 * DEPTH));
        idx     = legal ? int'((addr - BASE) >> 2) : 0;
        e.resp  = legal ? 2'b00 : 2'b01;
        e.waits = legal ? waitsOf(d) : 1;
        e.data  = (legal && !wr) ? model[d][idx] : 32'h0;
        sbq.push_back(e);
        hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = wr; haddr[d] = addr; hsize[d] = size;
        @(posedge hclk); #1;
        idleBus(d);
        hwdata[d] = wdata;
        waitsSeen = 0; cycles = 0; done = 1'b0;
        while (!done && cycles < 20) begin
            @(negedge hclk);
            cycles++;
            if (hready_out[d] === 1'b1) begin
                done = 1'b1;
            end else begin
                waitsSeen++;
                nCompared++;
                if (hresp[d] !== e.resp) begin
                    nMismatched++;
                    $display("[TB] FAIL %s wait_hresp: got %b want %b", tag, hresp[d], e.resp);
                end
            end
        end
        got = sbq.pop_front();
        nCompared++;
        if (!done) begin
            nMismatched++;
            $display("[TB] FAIL %s timeout: hready_out stuck at %b, want 1", tag, hready_out[d]);
        end else begin
            if (waitsSeen != got.waits) begin
                nMismatched++;
                $display("[TB] FAIL %s waits: got %0d want %0d", tag, waitsSeen, got.waits);
            end
            nCompared++;
            if (hresp[d] !== got.resp) begin
                nMismatched++;
                $display("[TB] FAIL %s hresp: got %b want %b", tag, hresp[d], got.resp);
            end
            nCompared++;
            if (hrdata[d] !== got.data) begin
                nMismatched++;
                $display("[TB] FAIL %s hrdata: got %h want %h", tag, hrdata[d], got.data);
            end
        end
        if (legal && wr) model[d][idx] = wdata;
        if (!legal) expErr[d]++;
        @(posedge hclk); #1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            hrest[d] = 1'b1;
            idleBus(d);
            hwdata[d] = 32'h0;
            expErr[d] = 0;
            for (int i = 0; i < DEPTH; i++) model[d][i] = 32'h0;
        end
        repeat (3) @(posedge hclk);
        #1;
        for (int d = 0; d < 3; d++) begin
            nCompared++;
            if (hready_out[d] !== 1'b1 || hresp[d] !== 2'b00 || hrdata[d] !== 32'h0 ||
                err_cnt[d] !== 16'h0) begin
                nMismatched++;
                $display("[TB] FAIL reset_%0d: rdy=%b resp=%b rdata=%h err=%h want 1/00/0/0",
                         d, hready_out[d], hresp[d], hrdata[d], err_cnt[d]);
            end
            hrest[d] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        e.resp = 2'b00; e.data = 32'h0;         e.waits = 0; sbq.push_back(e);
        e.resp = 2'b00; e.data = 32'hDEAD_BEEF; e.waits = 0; sbq.push_back(e);
        hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b1; haddr[0] = BASE + 32'd8;
        @(posedge hclk); #1;
        hwdata[0] = 32'hDEAD_BEEF;
        hwrite[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge hclk);
            e = sbq.pop_front();
            nCompared++;
            if (hready_out[0] !== 1'b1 || hresp[0] !== e.resp || hrdata[0] !== e.data) begin
                nMismatched++;
                $display("[TB] FAIL b2b_%0d: rdy=%b resp=%b rdata=%h want 1/%b/%h",
                         k, hready_out[0], hresp[0], hrdata[0], e.resp, e.data);
            end
            @(posedge hclk); #1;
            idleBus(0);
        end
        model[0][2] = 32'hDEAD_BEEF;
    endtask

    task automatic test_wait_states();
        logic [31:0] v;
        applyStimulus(1, 1'b0, BASE, 2'b10, 32'h0, "ws_first_read");
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            applyStimulus(1, 1'b1, BASE + 32'(20 * i), 2'b10, v, "ws_write");
        end
        applyStimulus(1, 1'b1, BASE + 32'(4 * DEPTH - 4), 2'b10, 32'hA5A5_0F0F, "ws_last_wr");
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(1, 1'b0, BASE + 32'(20 * i), 2'b10, 32'h0, "ws_read");
        end
        applyStimulus(1, 1'b0, BASE + 32'(4 * DEPTH - 4), 2'b10, 32'h0, "ws_last_rd");
    endtask

    task automatic test_errors();
        applyStimulus(0, 1'b0, BASE + 32'(4 * DEPTH), 2'b10, 32'h0, "err_range");
        applyStimulus(0, 1'b1, BASE + 32'd4, 2'b01, 32'h5555_AAAA, "err_size");
        applyStimulus(0, 1'b0, BASE + 32'd10, 2'b10, 32'h0, "err_align");
        nCompared++;
        if (err_cnt[0] !== 16'(expErr[0])) begin
            nMismatched++;
            $display("[TB] FAIL err_cnt3: got %0d want %0d", err_cnt[0], expErr[0]);
        end
        applyStimulus(0, 1'b0, BASE + 32'd4, 2'b10, 32'h0, "err_mem_intact");
        applyStimulus(0, 1'b0, BASE - 32'd4, 2'b10, 32'h0, "err_below");
        nCompared++;
        if (err_cnt[0] !== 16'(expErr[0])) begin
            nMismatched++;
            $display("[TB] FAIL err_cnt4: got %0d want %0d", err_cnt[0], expErr[0]);
        end
    endtask

    task automatic test_error_pipeline();
        exp_t e;
        hsel[0] = 1'b1; htrans[0] = 2'b11; hwrite[0] = 1'b0; haddr[0] = BASE + 32'h200;
        @(posedge hclk); #1;
        idleBus(0);
        @(negedge hclk);
        nCompared++;
        if (hready_out[0] !== 1'b0 || hresp[0] !== 2'b01) begin
            nMismatched++;
            $display("[TB] FAIL pipe_err1: rdy=%b resp=%b want 0/01", hready_out[0], hresp[0]);
        end
        @(posedge hclk); #1;
        e.resp = 2'b00; e.data = model[0][2]; e.waits = 0; sbq.push_back(e);
        hsel[0] = 1'b1; htrans[0] = 2'b10; hwrite[0] = 1'b0; haddr[0] = BASE + 32'd8;
        @(negedge hclk);
        nCompared++;
        if (hready_out[0] !== 1'b1 || hresp[0] !== 2'b01 || hrdata[0] !== 32'h0) begin
            nMismatched++;
            $display("[TB] FAIL pipe_err2: rdy=%b resp=%b rdata=%h want 1/01/0",
                     hready_out[0], hresp[0], hrdata[0]);
        end
        @(posedge hclk); #1;
        idleBus(0);
        expErr[0]++;
        @(negedge hclk);
        e = sbq.pop_front();
        nCompared++;
        if (hready_out[0] !== 1'b1 || hresp[0] !== e.resp || hrdata[0] !== e.data) begin
            nMismatched++;
            $display("[TB] FAIL pipe_read: rdy=%b resp=%b rdata=%h want 1/%b/%h",
                     hready_out[0], hresp[0], hrdata[0], e.resp, e.data);
        end
        @(posedge hclk); #1;
        nCompared++;
        if (err_cnt[0] !== 16'(expErr[0])) begin
            nMismatched++;
            $display("[TB] FAIL pipe_err_cnt: got %0d want %0d", err_cnt[0], expErr[0]);
        end
    endtask

    task automatic test_not_accepted();
        hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = BASE + 32'd16;
        hready_in[1] = 1'b0;
        hwdata[1] = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                hready_in[1] = 1'b1;
                htrans[1] = 2'b01;
            end
            @(negedge hclk);
            nCompared++;
            if (hready_out[1] !== 1'b1 || hresp[1] !== 2'b00) begin
                nMismatched++;
                $display("[TB] FAIL no_accept_%0d: rdy=%b resp=%b want 1/00",
                         k, hready_out[1], hresp[1]);
            end
            @(posedge hclk); #1;
        end
        idleBus(1);
        applyStimulus(1, 1'b0, BASE + 32'd16, 2'b10, 32'h0, "no_accept_mem");
    endtask

    task automatic test_reset_mid_wait();
        hsel[2] = 1'b1; htrans[2] = 2'b10; hwrite[2] = 1'b1; haddr[2] = BASE + 32'd12;
        @(posedge hclk); #1;
        idleBus(2);
        hwdata[2] = 32'hCAFE_F00D;
        @(negedge hclk);
        nCompared++;
        if (hready_out[2] !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL rst_wait1: rdy=%b want 0", hready_out[2]);
        end
        @(posedge hclk); #1;
        hrest[2] = 1'b1;
        #1;
        nCompared++;
        if (hready_out[2] !== 1'b1 || hresp[2] !== 2'b00 || hrdata[2] !== 32'h0 ||
            err_cnt[2] !== 16'h0) begin
            nMismatched++;
            $display("[TB] FAIL rst_async: rdy=%b resp=%b rdata=%h err=%h want 1/00/0/0",
                     hready_out[2], hresp[2], hrdata[2], err_cnt[2]);
        end
        @(posedge hclk); #1;
        hrest[2] = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[2][i] = 32'h0;
        applyStimulus(2, 1'b0, BASE + 32'd12, 2'b10, 32'h0, "rst_readback");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        applyStimulus(0, 1'b0, BASE + 32'd8, 2'b10, 32'h0, "first_read");
        test_back_to_back();
        test_wait_states();
        test_errors();
        test_error_pipeline();
        test_not_accepted();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/eva_ahb_slv.md
EVA_AHB_SLV -- requirements
Module: eva_ahb_slv

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit memory words (power of 2, 4..1024).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0 (DEPTH*4 aligned).
REQ-003 Parameter WAIT_CYC, default 0: wait states inserted per data phase (0..7).
REQ-004 hclk  input  1  sole clock; all state updates on rising edge.
REQ-005 hrest  input  1  asynchronous, active-high reset.
REQ-006 hsel  input  1  slave select.
REQ-007 htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 hwrite  input  1  1 = write, 0 = read.
REQ-009 haddr  input  32  byte address.
REQ-010 hsize  input  2  transfer size; only 2'b10 (word) is legal.
REQ-011 hwdata  input  32  write data, sampled in the write data phase.
REQ-012 hready_in  input  1  bus ready; an address phase is accepted only when high.
REQ-013 hready_out  output  1  data phase completion; low = wait.
REQ-014 hresp  output  2  00 OKAY, 01 ERROR.
REQ-015 hrdata  output  32  read data.
REQ-016 err_cnt  output  16  count of ERROR responses issued, saturating at 16'hFFFF.

Function
REQ-017 Accept: address phase valid when hsel & htrans[1] & hready_in; capture haddr, hwrite, hsize; BUSY/IDLE/unselected cycles get OKAY with zero wait.
REQ-018 Legality: transfer is legal if hsize == 2'b10, haddr[1:0] == 0, and BASE_ADDR <= haddr < BASE_ADDR + 4*DEPTH; otherwise illegal.
REQ-019 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-020 IDLE: hready_out=1, hresp=00; accepted legal transfer -> WAIT if WAIT_CYC>0, else data phase completes next cycle (stay IDLE, data phase handled in same cycle as next address phase); accepted illegal transfer -> ERR1.
REQ-021 WAIT: hready_out=0, hresp=00 for exactly WAIT_CYC cycles (internal 3-bit counter), then one cycle hready_out=1 completing the data phase; a new address phase accepted in that cycle is handled per REQ-020.
REQ-022 ERR1: hready_out=0, hresp=01 for one cycle -> ERR2; ERR2: hready_out=1, hresp=01 for one cycle, err_cnt increments at its end; no memory write, hrdata=0.
REQ-023 Address phase accepted during ERR2 is processed normally (back-to-back pipelining).
REQ-024 Write: memory word (haddr-BASE_ADDR)>>2 updated with hwdata at the rising edge ending the completing data-phase cycle (hready_out=1).
REQ-025 Read: hrdata = memory word of captured address during the completing data-phase cycle; hrdata=0 in all other cycles.
REQ-026 Read immediately after a write to the same word returns the new data (write commits before the read data phase completes).
REQ-027 Wait cycles, errors and completion ignore hsel/htrans changes during the data phase; pipeline holds at most one pending transfer.

Reset
REQ-028 On hrest assertion (any cycle, including mid-WAIT or mid-ERR): FSM -> IDLE, wait counter=0, hready_out=1, hresp=00, hrdata=0, err_cnt=0, all memory words=0; in-flight transfer abandoned with no memory write.
REQ-029 First address phase is accepted on the first rising edge with hrest low.

Verification
REQ-030 WAIT_CYC=0: write 32'hDEAD_BEEF to BASE+8, then read BASE+8 back-to-back -> hready_out never low, hrdata=32'hDEAD_BEEF in read data cycle, hresp=00.
REQ-031 WAIT_CYC=3: single read of BASE+0 after reset -> hready_out low exactly 3 cycles, then hrdata=0, hresp=00.
REQ-032 Read at BASE+4*DEPTH, then hsize=2'b01 write, then haddr[1:0]=2'b10 read -> each gives ERR1/ERR2 two-cycle response (hready_out 0 then 1, hresp=01), err_cnt=3, memory unchanged.
REQ-033 NONSEQ with hready_in=0, and htrans=BUSY with hsel=1 -> not accepted, hready_out=1, hresp=00, no memory change.
REQ-034 WAIT_CYC=5: assert hrest during 2nd wait cycle of a write to BASE+12 -> hready_out=1, hresp=00 immediately; subsequent read of BASE+12 returns 0.
